vga_embarcacao: RTL

VGA_EMBARCACAO -- requirements
Module: vga_embarcacao

---
 rtl/vga_embarcacao.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vga_embarcacao.sv
// Ship sprite for a battleship VGA display: draws up to TAM grid cells and
// tracks hits on them (intact, damaged/blinking, sunk).

module vga_embarcacao_celula #(
  parameter logic [9:0] LARGURA = 10'd54,
  parameter logic [9:0] ALTURA  = 10'd49,
  parameter logic [9:0] PASSO_X = 10'd62,
  parameter logic [9:0] PASSO_Y = 10'd57,
  parameter logic [9:0] ORIGEM  = 10'd16
) (
  input  logic [7:0] pos,
  input  logic [9:0] linha,
  input  logic [9:0] coluna,
  input  logic [3:0] tiro_x,
  input  logic [3:0] tiro_y,
  output logic       ativa,
  output logic       dentro,
  output logic       alvo
);
  logic [3:0] x, y;
  logic [9:0] left, down;

  assign x = pos[3:0];
  assign y = pos[7:4];
  assign ativa = (x >= 4'd1) && (x <= 4'd8) && (y >= 4'd1) && (y <= 4'd8);

  // Disabled cells may wrap here; they are masked by ativa.
  assign left = ORIGEM + ({6'd0, x} - 10'd1) * PASSO_X;
  assign down = ORIGEM + ({6'd0, y} - 10'd1) * PASSO_Y;

  assign dentro = ativa && (coluna > left) && (coluna < left + LARGURA) &&
                  (linha > down) && (linha < down + ALTURA);
  assign alvo   = ativa && (x == tiro_x) && (y == tiro_y);
endmodule

module vga_embarcacao #(
  parameter int         TAM       = 3,
  parameter logic [2:0] COR       = 3'b010,
  parameter logic [9:0] LARGURA   = 10'd54,
  parameter logic [9:0] ALTURA    = 10'd49,
  parameter logic [9:0] PASSO_X   = 10'd62,
  parameter logic [9:0] PASSO_Y   = 10'd57,
  parameter logic [9:0] ORIGEM    = 10'd16,
  parameter int         BLINK_DIV = 12_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             areaAtiva,
  input  logic [9:0]       linha,
  input  logic [9:0]       coluna,
  input  logic             carregar,
  input  logic [8*TAM-1:0] posicoes,
  input  logic             tiro_valido,
  input  logic [3:0]       tiro_x,
  input  logic [3:0]       tiro_y,
  output logic             rgb_r,
  output logic             rgb_g,
  output logic             rgb_b,
  output logic             acerto,
  output logic             afundado
);
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {VAZIO, INTACTO, AVARIADO, AFUNDADO} estado_t;

  estado_t          state_q, state_d;
  logic [8*TAM-1:0] pos_q;
  logic [TAM-1:0]   hit_q, hit_d, novo;
  logic [TAM-1:0]   ativa, dentro, alvo;
  logic             acerto_d;
  logic [CW-1:0]    cnt_q;
  logic             fase_q;
  logic             sel_ok, sel_hit;
  logic [2:0]       cor_d, cor_q;

  for (genvar g = 0; g < TAM; g++) begin : g_cel
    vga_embarcacao_celula #(
      .LARGURA(LARGURA), .ALTURA(ALTURA), .PASSO_X(PASSO_X),
      .PASSO_Y(PASSO_Y), .ORIGEM(ORIGEM)
    ) u_cel (
      .pos    (pos_q[8*g +: 8]),
      .linha  (linha),
      .coluna (coluna),
      .tiro_x (tiro_x),
      .tiro_y (tiro_y),
      .ativa  (ativa[g]),
      .dentro (dentro[g]),
      .alvo   (alvo[g])
    );
  end

  assign novo = alvo & ~hit_q;

  always_comb begin
    state_d  = state_q;
    hit_d    = hit_q;
    acerto_d = 1'b0;
    if (carregar) begin
      state_d = INTACTO;
      hit_d   = '0;
    end else if (tiro_valido && (state_q == INTACTO || state_q == AVARIADO) && |novo) begin
      hit_d    = hit_q | novo;
      acerto_d = 1'b1;
      state_d  = ((hit_d & ativa) == ativa) ? AFUNDADO : AVARIADO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VAZIO;
      hit_q   <= '0;
      pos_q   <= '0;
      acerto  <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      acerto  <= acerto_d;
      if (carregar) pos_q <= posicoes;
    end
  end

  assign afundado = (state_q == AFUNDADO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fase_q <= 1'b0;
    end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
      cnt_q  <= '0;
      fase_q <= ~fase_q;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Downward scan so the lowest-indexed overlapping cell is selected last.
  always_comb begin
    sel_ok  = 1'b0;
    sel_hit = 1'b0;
    for (int i = TAM - 1; i >= 0; i--) begin
      if (dentro[i]) begin
        sel_ok  = 1'b1;
        sel_hit = hit_q[i];
      end
    end
  end

  always_comb begin
    cor_d = 3'b000;
    if (areaAtiva && sel_ok && state_q != VAZIO) begin
      if (!sel_hit)                        cor_d = COR;
      else if (state_q == AFUNDADO)        cor_d = 3'b100;
      else if (state_q == AVARIADO && fase_q) cor_d = 3'b100;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cor_q <= 3'b000;
    else        cor_q <= cor_d;
  end

  assign {rgb_r, rgb_g, rgb_b} = cor_q;
endmodule
